// File: rtl/fpu_result_buffer.sv
// ---------------------------------------------------------------------------
// fpu_result_buffer
//
// Writeback buffer sitting behind the FPU. Every result the FPU presents is
// captured into a small first-word-fall-through FIFO and replayed to the
// register-file writeback port through a valid/ready handshake. The buffer
// throttles the FPU through fpu_stall_o early enough that results already in
// flight inside the FPU pipeline (up to SKID of them) still fit. It also keeps
// a sticky, fcsr-style accumulation of the IEEE exception flags of every
// result handed to writeback.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active low
//   fpu_valid_i    FPU result valid
//   fpu_result_i   FPU result value                     [RS_W]
//   fpu_fflags_i   FPU exception flags (NV,DZ,OF,UF,NX)  [FF_W]
//   fpu_error_i    FPU error indication                 [ERR_W]
//   fpu_user_i     FPU user tag                         [USR_W]
//   fpu_stall_o    stall request to the FPU (registered)
//   wb_valid_o     head entry present
//   wb_ready_i     writeback port accepts the head entry
//   wb_result_o    head entry result                    [RS_W]
//   wb_fflags_o    head entry flags                     [FF_W]
//   wb_error_o     head entry error                     [ERR_W]
//   wb_user_o      head entry user tag                  [USR_W]
//   acc_fflags_o   sticky OR of flags of popped entries [FF_W]
//   clr_flags_i    clear the accumulated flags
//   overflow_o     sticky: a result arrived while full and was dropped
//   count_o        current occupancy                    [CNT_W]
// ---------------------------------------------------------------------------
module fpu_result_buffer #(
    parameter int RS_W  = 32,
    parameter int FF_W  = 5,
    parameter int ERR_W = 1,
    parameter int USR_W = 8,
    parameter int DEPTH = 4,
    parameter int SKID  = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             fpu_valid_i,
    input  logic [RS_W-1:0]  fpu_result_i,
    input  logic [FF_W-1:0]  fpu_fflags_i,
    input  logic [ERR_W-1:0] fpu_error_i,
    input  logic [USR_W-1:0] fpu_user_i,
    output logic             fpu_stall_o,

    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [RS_W-1:0]  wb_result_o,
    output logic [FF_W-1:0]  wb_fflags_o,
    output logic [ERR_W-1:0] wb_error_o,
    output logic [USR_W-1:0] wb_user_o,

    output logic [FF_W-1:0]  acc_fflags_o,
    input  logic             clr_flags_i,
    output logic             overflow_o,
    output logic [CNT_W-1:0] count_o
);

    // Pointers wrap naturally because DEPTH is a power of two.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    // Stall as soon as only SKID free slots remain, so the results the FPU
    // still emits after seeing stall land in those reserved slots.
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    // ------------------------------------------------------------------
    // Storage: data only, never reset
    // ------------------------------------------------------------------
    logic [RS_W-1:0]  res_mem_q [DEPTH];
    logic [FF_W-1:0]  ff_mem_q  [DEPTH];
    logic [ERR_W-1:0] err_mem_q [DEPTH];
    logic [USR_W-1:0] usr_mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wp_q,    wp_d;
    logic [PTR_W-1:0] rp_q,    rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic [FF_W-1:0]  acc_q,   acc_d;
    logic             ovf_q,   ovf_d;

    logic             push;
    logic             pop;
    logic             not_empty;
    logic             not_full;

    // ------------------------------------------------------------------
    // Head of queue (first-word fall-through)
    // ------------------------------------------------------------------
    assign not_empty   = (count_q != '0);
    assign not_full    = (count_q != FULL_CNT);

    assign wb_valid_o  = not_empty;
    assign wb_result_o = res_mem_q[rp_q];
    assign wb_fflags_o = ff_mem_q[rp_q];
    assign wb_error_o  = err_mem_q[rp_q];
    assign wb_user_o   = usr_mem_q[rp_q];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pop  = not_empty && wb_ready_i;
        // A full buffer still accepts a result when the head leaves in the
        // same cycle; the freed slot is the one being written.
        push = fpu_valid_i && (not_full || pop);

        wp_d = push ? (wp_q + ONE_PTR) : wp_q;
        rp_d = pop  ? (rp_q + ONE_PTR) : rp_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        // Based on the post-update occupancy so stall reacts in the cycle
        // right after the push that reaches the threshold.
        stall_d = (count_d >= STALL_CNT);

        // Clear wins over accumulation, but the flags of an entry popped in
        // the clearing cycle are not lost: they seed the new value.
        acc_d = acc_q;
        if (clr_flags_i && pop) begin
            acc_d = wb_fflags_o;
        end else if (clr_flags_i) begin
            acc_d = '0;
        end else if (pop) begin
            acc_d = acc_q | wb_fflags_o;
        end

        // A valid result that could not be pushed is a dropped result.
        ovf_d = ovf_q || (fpu_valid_i && !push);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            stall_q <= stall_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry write
    // ------------------------------------------------------------------
    // Gated by rst so a result arriving during reset is not half-captured;
    // the contents themselves are meaningless until count covers them.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            res_mem_q[wp_q] <= fpu_result_i;
            ff_mem_q[wp_q]  <= fpu_fflags_i;
            err_mem_q[wp_q] <= fpu_error_i;
            usr_mem_q[wp_q] <= fpu_user_i;
        end
    end

    assign fpu_stall_o  = stall_q;
    assign acc_fflags_o = acc_q;
    assign overflow_o   = ovf_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
module tb_fpu_result_buffer;

    localparam int RS_W  = 32;
    localparam int FF_W  = 5;
    localparam int ERR_W = 1;
    localparam int USR_W = 8;
    localparam int DEPTH = 4;
    localparam int SKID  = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [RS_W-1:0]  res;
        logic [FF_W-1:0]  ff;
        logic [ERR_W-1:0] err;
        logic [USR_W-1:0] usr;
    } entry_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fpu_valid_i = 1'b0;
    logic [RS_W-1:0]  fpu_result_i = '0;
    logic [FF_W-1:0]  fpu_fflags_i = '0;
    logic [ERR_W-1:0] fpu_error_i = '0;
    logic [USR_W-1:0] fpu_user_i = '0;
    logic             fpu_stall_o;
    logic             wb_valid_o;
    logic             wb_ready_i = 1'b0;
    logic [RS_W-1:0]  wb_result_o;
    logic [FF_W-1:0]  wb_fflags_o;
    logic [ERR_W-1:0] wb_error_o;
    logic [USR_W-1:0] wb_user_o;
    logic [FF_W-1:0]  acc_fflags_o;
    logic             clr_flags_i = 1'b0;
    logic             overflow_o;
    logic [CNT_W-1:0] count_o;

    int     checks = 0;
    int     errors = 0;
    entry_t sb_q[$];
    int     mcount = 0;

    fpu_result_buffer #(
        .RS_W(RS_W), .FF_W(FF_W), .ERR_W(ERR_W), .USR_W(USR_W),
        .DEPTH(DEPTH), .SKID(SKID), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_result_i (fpu_result_i),
        .fpu_fflags_i (fpu_fflags_i),
        .fpu_error_i  (fpu_error_i),
        .fpu_user_i   (fpu_user_i),
        .fpu_stall_o  (fpu_stall_o),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_result_o  (wb_result_o),
        .wb_fflags_o  (wb_fflags_o),
        .wb_error_o   (wb_error_o),
        .wb_user_o    (wb_user_o),
        .acc_fflags_o (acc_fflags_o),
        .clr_flags_i  (clr_flags_i),
        .overflow_o   (overflow_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic entry_t mk(input int i);
        entry_t e;
        e.res = 32'hC0DE_0000 + i;
        e.ff  = i[4:0];
        e.err = i[0];
        e.usr = 8'h10 + i[7:0];
        return e;
    endfunction

    // One clock cycle: drive inputs, record the head as seen before the edge,
    // update the reference occupancy and the scoreboard, then step past the edge.
    task automatic cyc(input logic v, input entry_t e, input logic rdy, input logic clr,
                       output logic popped, output entry_t head);
        fpu_valid_i  = v;
        fpu_result_i = e.res;
        fpu_fflags_i = e.ff;
        fpu_error_i  = e.err;
        fpu_user_i   = e.usr;
        wb_ready_i   = rdy;
        clr_flags_i  = clr;
        popped   = (mcount > 0) && rdy;
        head.res = wb_result_o;
        head.ff  = wb_fflags_o;
        head.err = wb_error_o;
        head.usr = wb_user_o;
        if (v && (mcount < DEPTH || popped)) begin
            sb_q.push_back(e);
            mcount++;
        end
        if (popped) mcount--;
        @(posedge clk); #1;
        fpu_valid_i = 1'b0;
        clr_flags_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        fpu_valid_i = 1'b0;
        wb_ready_i  = 1'b0;
        clr_flags_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        mcount = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wb_valid_o); end
        checks++; if (fpu_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", fpu_stall_o); end
        checks++; if (acc_fflags_o !== '0) begin errors++; $display("FAIL reset_acc: got %b expected 0", acc_fflags_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
        @(posedge clk); #1;
        checks++; if (wb_valid_o !== 1'b0 || count_o !== '0) begin errors++; $display("FAIL idle_after_reset: got valid=%b count=%0d expected 0/0", wb_valid_o, count_o); end
    endtask

    task automatic test_pass_through();
        logic p; entry_t h, e, exp;
        e.res = 32'h3F80_0000; e.ff = 5'b00001; e.err = 1'b0; e.usr = 8'hA5;
        cyc(1'b1, e, 1'b1, 1'b0, p, h);
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL pt_no_early_pop: got %b expected 0", p); end
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL pt_valid_rise: got %b expected 1", wb_valid_o); end
        cyc(1'b0, '0, 1'b1, 1'b0, p, h);
        if (p) begin
            exp = sb_q.pop_front();
            checks++; if (h !== exp) begin errors++; $display("FAIL pt_data: got %h expected %h", h, exp); end
        end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL pt_valid_one_cycle: got %b expected 0", wb_valid_o); end
        checks++; if (acc_fflags_o !== 5'b00001) begin errors++; $display("FAIL pt_acc: got %b expected 00001", acc_fflags_o); end
    endtask

    task automatic test_backpressure();
        logic p; entry_t h, exp;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, mk(20 + i), 1'b0, 1'b0, p, h);
            if (i == 0) begin
                checks++; if (fpu_stall_o !== 1'b0) begin errors++; $display("FAIL bp_stall_after_push1: got %b expected 0", fpu_stall_o); end
            end
            if (i == 1) begin
                checks++; if (fpu_stall_o !== 1'b1) begin errors++; $display("FAIL bp_stall_after_push2: got %b expected 1", fpu_stall_o); end
            end
        end
        checks++; if (count_o !== CNT_W'(4)) begin errors++; $display("FAIL bp_count_full: got %0d expected 4", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL bp_no_overflow: got %b expected 0", overflow_o); end
        checks++; if (wb_result_o !== sb_q[0].res || wb_user_o !== sb_q[0].usr) begin errors++; $display("FAIL bp_head: got %h/%h expected %h/%h", wb_result_o, wb_user_o, sb_q[0].res, sb_q[0].usr); end
        cyc(1'b0, '0, 1'b0, 1'b0, p, h);
        checks++; if (wb_result_o !== sb_q[0].res || count_o !== CNT_W'(4)) begin errors++; $display("FAIL bp_head_stable: got %h cnt %0d expected %h cnt 4", wb_result_o, count_o, sb_q[0].res); end
        for (int k = 0; k < 3 * DEPTH && mcount > 0; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, p, h);
            if (p) begin
                exp = sb_q.pop_front();
                checks++; if (h !== exp) begin errors++; $display("FAIL bp_drain_order: got %h expected %h", h, exp); end
            end
            checks++; if (count_o !== CNT_W'(mcount)) begin errors++; $display("FAIL bp_drain_count: got %0d expected %0d", count_o, mcount); end
            checks++; if (fpu_stall_o !== 1'(mcount >= DEPTH - SKID)) begin errors++; $display("FAIL bp_drain_stall: got %b at count %0d", fpu_stall_o, mcount); end
        end
    endtask

    task automatic test_overflow();
        logic p; entry_t h, exp;
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, mk(40 + i), 1'b0, 1'b0, p, h);
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow_o); end
        checks++; if (count_o !== CNT_W'(4)) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count_o); end
        for (int k = 0; k < 3 * DEPTH && mcount > 0; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, p, h);
            if (p) begin
                exp = sb_q.pop_front();
                checks++; if (h !== exp) begin errors++; $display("FAIL ovf_drain: got %h expected %h", h, exp); end
            end
        end
        checks++; if (wb_valid_o !== 1'b0 || count_o !== '0) begin errors++; $display("FAIL ovf_fifth_dropped: got valid=%b count=%0d expected 0/0", wb_valid_o, count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
    endtask

    task automatic test_full_push_pop();
        logic p; entry_t h, exp;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, mk(60 + i), 1'b0, 1'b0, p, h);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, mk(70 + i), 1'b1, 1'b0, p, h);
            if (p) begin
                exp = sb_q.pop_front();
                checks++; if (h !== exp) begin errors++; $display("FAIL fpp_order: got %h expected %h", h, exp); end
            end
            checks++; if (count_o !== CNT_W'(4) || overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_count: got cnt=%0d ovf=%b expected 4/0", count_o, overflow_o); end
        end
        for (int k = 0; k < 3 * DEPTH && mcount > 0; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, p, h);
            if (p) begin
                exp = sb_q.pop_front();
                checks++; if (h !== exp) begin errors++; $display("FAIL fpp_drain: got %h expected %h", h, exp); end
            end
        end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL fpp_empty: got %0d expected 0", count_o); end
    endtask

    task automatic test_flags();
        logic p; entry_t h, exp, e;
        logic [FF_W-1:0] fl [3];
        logic [FF_W-1:0] want [3];
        fl[0] = 5'b00001; fl[1] = 5'b10000; fl[2] = 5'b00100;
        want[0] = 5'b00001; want[1] = 5'b10001; want[2] = 5'b00100;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            e = mk(90 + i);
            e.ff = fl[i];
            cyc(1'b1, e, 1'b0, 1'b0, p, h);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, (i == 2), p, h);
            if (p) begin
                exp = sb_q.pop_front();
                checks++; if (h !== exp) begin errors++; $display("FAIL flags_data: got %h expected %h", h, exp); end
            end
            checks++; if (acc_fflags_o !== want[i]) begin errors++; $display("FAIL flags_acc%0d: got %b expected %b", i, acc_fflags_o, want[i]); end
        end
        cyc(1'b0, '0, 1'b0, 1'b1, p, h);
        checks++; if (acc_fflags_o !== '0) begin errors++; $display("FAIL flags_clear: got %b expected 00000", acc_fflags_o); end
    endtask

    task automatic test_reset_mid();
        logic p; entry_t h, exp;
        apply_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, mk(110 + i), 1'b0, 1'b0, p, h);
        checks++; if (count_o !== CNT_W'(3) || fpu_stall_o !== 1'b1) begin errors++; $display("FAIL rm_pending: got cnt=%0d stall=%b expected 3/1", count_o, fpu_stall_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", wb_valid_o); end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL rm_count: got %0d expected 0", count_o); end
        checks++; if (fpu_stall_o !== 1'b0) begin errors++; $display("FAIL rm_stall: got %b expected 0", fpu_stall_o); end
        rst = 1'b1;
        sb_q.delete();
        mcount = 0;
        cyc(1'b1, mk(130), 1'b0, 1'b0, p, h);
        cyc(1'b0, '0, 1'b1, 1'b0, p, h);
        if (p) begin
            exp = sb_q.pop_front();
            checks++; if (h !== exp) begin errors++; $display("FAIL rm_after_reset_data: got %h expected %h", h, exp); end
        end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL rm_after_reset_count: got %0d expected 0", count_o); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_flags();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
